reg_access_arbiter: RTL and testbench
=====================================

// Module: reg_access_arbiter
// PURPOSE
//  Shares the single-port register bank between two masters: A = I2C slave controller byte
//  accesses, B = internal monitor/safety logic (status, ADC peak/CW power, limit reloads).
//  One access per cycle. Round-robin fairness, with an optional B lock for atomic multi-byte
//  updates. A bounded lock timeout stops I2C clock stretching from being held indefinitely.
// PARAMETERS
//  ADDR_W    8   register address width
//  DATA_W    8   register data width
//  LOCK_MAX  16  max consecutive B grants under lock before A must be served (>=2)
// PORTS
//  clk         in   1       system clock
//  rstn        in   1       asynchronous active-low reset
//  a_req       in   1       A access request; held with a_we/a_addr/a_wdata stable until a_gnt
//  a_we        in   1       A write(1)/read(0)
//  a_addr      in   ADDR_W  A address
//  a_wdata     in   DATA_W  A write data
//  a_gnt       out  1       A access issued this cycle (combinational)
//  a_rvalid    out  1       A read data valid (registered)
//  a_rdata     out  DATA_W  A read data
//  a_stall     out  1       a_req & ~a_gnt; drives I2C stretch_on
//  b_req       in   1       B access request (same hold rule)
//  b_lock      in   1       B requests to keep ownership for the next beat
//  b_we        in   1       B write/read
//  b_addr      in   ADDR_W  B address
//  b_wdata     in   DATA_W  B write data
//  b_gnt       out  1       B access issued this cycle
//  b_rvalid    out  1       B read data valid
//  b_rdata     out  DATA_W  B read data
//  bank_en     out  1       bank access strobe (= a_gnt | b_gnt)
//  bank_we     out  1       bank write enable
//  bank_addr   out  ADDR_W  muxed address
//  bank_wdata  out  DATA_W  muxed write data
//  bank_rdata  in   DATA_W  bank read data, valid 1 cycle after a read strobe
// BEHAVIOUR
//  - Reset (async, rstn=0): prio=A, owner=NONE, lock_cnt=0, a/b_rvalid=0, a/b_rdata=0.
//    Combinational outputs follow inputs; bank_en=0 while no request.
//  - a_gnt and b_gnt are never high together. A grant takes the same cycle as the request;
//    bank_* mirror the granted master's fields.
//  - States (owner): NONE, A, B_LOCKED.
//    - NONE/A: if only one master requests, grant it. If both request, grant prio and then
//      flip prio to the other master.
//    - B granted with b_lock=1: go to B_LOCKED. lock_cnt counts B grants in the lock
//      (1 on entry).
//    - B_LOCKED: B wins ties while b_lock=1 and lock_cnt<LOCK_MAX.
//      Exit to NONE on b_lock=0 at a B grant, on b_req=0, or on lock_cnt==LOCK_MAX.
//      On exit, prio=A and lock_cnt is cleared.
//      If A is pending at lock_cnt==LOCK_MAX, A gets the next cycle.
//  - Worst-case A wait: LOCK_MAX cycles. Without lock: 1 cycle.
//  - Read return: the master whose read was granted in cycle N sees rvalid=1 in N+1.
//    rdata = bank_rdata, registered and held until that master's next read returns.
//    Writes produce no rvalid.
//  - Back-to-back reads from different masters: each rvalid is routed by a registered
//    owner tag, never crossed.
//  - Write followed by read to the same address in the next cycle returns the new value
//    (bank write-first in cycle N).
//  - A request dropped before grant is a protocol violation: no grant, state unchanged.
//  - Reset mid-read: the pending rvalid is discarded. No bank strobe is issued while rstn=0.
// STRUCTURE
//  - reg_arb_pkg: ADDR_W/DATA_W defaults; owner encoding OWN_NONE=2'd0, OWN_A=2'd1,
//    OWN_B_LOCKED=2'd2; rd_tag encoding.
//  - One sub-module, arb_lock_timer: lock_cnt, saturate/expire flag, clear on exit or reset.
//  - Top level holds the owner FSM, prio flop, grant/mux logic and the read-return tag pipe.
// TESTING
//  - Reset mid-read:
//    - Stimulus: rstn low while B read is in flight.
//    - Required: a/b_rvalid=0 next cycle; bank_en=0 during reset; after release, first
//      grant goes to A on a tie.
//  - A-only traffic:
//    - Stimulus: a_req read 0x10 with bank holding 0x5A.
//    - Required: a_gnt same cycle, bank_addr=0x10, a_rvalid=1 and a_rdata=0x5A next cycle,
//      a_stall never high.
//  - Tie, round-robin:
//    - Stimulus: a_req and b_req both held high for 4 cycles, prio=A.
//    - Required: grants A,B,A,B; a_stall high on cycles 2 and 4 only.
//  - B lock and timeout (LOCK_MAX=16):
//    - Stimulus: b_lock=1, b_req=1 continuously, a_req asserted at B's 3rd beat.
//    - Required: B granted 16 consecutive cycles, A granted on the 17th, prio=A after.
//  - Cross-tagged reads:
//    - Stimulus: A read 0x02 (0x11) then B read 0x03 (0x22) back to back.
//    - Required: a_rvalid with 0x11 in cycle N+1, b_rvalid with 0x22 in cycle N+2,
//      no crossing.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register bank arbiter: default widths,
// owner state encoding, read-return tag encoding and round-robin priority.
package reg_arb_pkg;

    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_LOCK_MAX = 16;

    typedef enum logic [1:0] {
        OWN_NONE     = 2'd0,
        OWN_A        = 2'd1,
        OWN_B_LOCKED = 2'd2
    } owner_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } rd_tag_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

endpackage

// File: rtl/arb_lock_timer.sv
// Counts B grants issued under a lock and flags the beat that uses up the
// last allowed slot, so the owner FSM can hand the bank back to A.
module arb_lock_timer #(
    parameter  int LOCK_MAX = 16,
    localparam int CNT_W    = $clog2(LOCK_MAX + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic count,
    input  logic clear,
    output logic lock_last
);

    logic [CNT_W-1:0] lock_cnt;

    // Lock beat counter: clear wins over count, saturates at LOCK_MAX.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock_cnt <= '0;
        end else if (clear) begin
            lock_cnt <= '0;
        end else if (count && (lock_cnt != CNT_W'(LOCK_MAX))) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign lock_last = (lock_cnt == CNT_W'(LOCK_MAX - 1));

endmodule

// File: rtl/reg_access_arbiter.sv
// Two-master arbiter for the single-port register bank. A is the I2C slave
// controller, B the internal monitor logic. One access per cycle, round-robin
// on ties, optional B lock for atomic multi-byte updates bounded by LOCK_MAX.
module reg_access_arbiter
    import reg_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_lock,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              bank_en,
    output logic              bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [DATA_W-1:0] bank_rdata
);

    owner_e            owner_q, owner_d;
    prio_e             prio_q, prio_d;
    rd_tag_e           rd_tag_q, rd_tag_d;
    logic              a_win, b_win;
    logic              lock_count, lock_clear, lock_last;
    logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

    arb_lock_timer #(.LOCK_MAX(LOCK_MAX)) u_lock_timer (
        .clk       (clk),
        .rstn      (rstn),
        .count     (lock_count),
        .clear     (lock_clear),
        .lock_last (lock_last)
    );

    // State register: owner, round-robin priority and read-return tag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q  <= OWN_NONE;
            prio_q   <= PRIO_A;
            rd_tag_q <= TAG_NONE;
        end else begin
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            rd_tag_q <= rd_tag_d;
        end
    end

    // Next state: lock entry/exit, priority flip on ties, read tag for the return.
    always_comb begin
        owner_d    = owner_q;
        prio_d     = prio_q;
        lock_count = 1'b0;
        lock_clear = 1'b0;
        rd_tag_d   = TAG_NONE;
        if (a_gnt && !a_we) begin
            rd_tag_d = TAG_A;
        end else if (b_gnt && !b_we) begin
            rd_tag_d = TAG_B;
        end
        case (owner_q)
            OWN_B_LOCKED: begin
                if (b_gnt && b_lock && !lock_last) begin
                    lock_count = 1'b1;
                end else if (b_gnt || a_gnt || !b_req) begin
                    owner_d    = OWN_NONE;
                    prio_d     = PRIO_A;
                    lock_clear = 1'b1;
                end
            end
            default: begin
                if (a_gnt && b_req) begin
                    prio_d = PRIO_B;
                end else if (b_gnt && a_req) begin
                    prio_d = PRIO_A;
                end
                if (b_gnt && b_lock) begin
                    owner_d    = OWN_B_LOCKED;
                    lock_count = 1'b1;
                end else if (a_gnt) begin
                    owner_d = OWN_A;
                end else if (b_gnt) begin
                    owner_d = OWN_NONE;
                end
            end
        endcase
    end

    // Outputs: pick the winner, gate strobes with reset, mux the bank fields.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (owner_q == OWN_B_LOCKED) begin
            if (b_req && (b_lock || !a_req)) begin
                b_win = 1'b1;
            end else if (a_req) begin
                a_win = 1'b1;
            end
        end else begin
            if (a_req && (!b_req || (prio_q == PRIO_A))) begin
                a_win = 1'b1;
            end else if (b_req) begin
                b_win = 1'b1;
            end
        end
        a_gnt      = a_win && rstn;
        b_gnt      = b_win && rstn;
        a_stall    = a_req && !a_gnt;
        bank_en    = a_gnt || b_gnt;
        bank_we    = a_gnt ? a_we : (b_gnt && b_we);
        bank_addr  = b_gnt ? b_addr : a_addr;
        bank_wdata = b_gnt ? b_wdata : a_wdata;
    end

    // Read data holding registers, loaded in the cycle each master's read returns.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_rvalid) begin
                a_rdata_q <= bank_rdata;
            end
            if (b_rvalid) begin
                b_rdata_q <= bank_rdata;
            end
        end
    end

    assign a_rvalid = (rd_tag_q == TAG_A);
    assign b_rvalid = (rd_tag_q == TAG_B);
    assign a_rdata  = a_rvalid ? bank_rdata : a_rdata_q;
    assign b_rdata  = b_rvalid ? bank_rdata : b_rdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: a behavioural register bank, a table of
// request/expected-grant vectors, hand-written lock and reset sequences, and
// a read-return scoreboard fed when reads are issued.
module tb_reg_access_arbiter;

    typedef struct {
        logic       a_req;
        logic       a_we;
        logic [7:0] a_addr;
        logic [7:0] a_wdata;
        logic       b_req;
        logic       b_lock;
        logic       b_we;
        logic [7:0] b_addr;
        logic [7:0] b_wdata;
        logic       exp_a_gnt;
        logic       exp_b_gnt;
    } vec_t;

    typedef struct {
        logic       is_b;
        logic [7:0] data;
        int         due;
    } rd_exp_t;

    logic       clk;
    logic       rstn;
    logic       a_req, a_we, b_req, b_lock, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, a_stall, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       bank_en, bank_we;
    logic [7:0] bank_addr, bank_wdata, bank_rdata;

    logic [7:0] mem [256];
    bit   [255:0] written;
    logic [7:0] exp_mem [256];
    rd_exp_t    rd_q[$];
    vec_t       tbl[$];
    int         cyc;
    int         n_checks;
    int         n_fail;
    bit         mon_en;

    reg_access_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .a_stall    (a_stall),
        .b_req      (b_req),
        .b_lock     (b_lock),
        .b_we       (b_we),
        .b_addr     (b_addr),
        .b_wdata    (b_wdata),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .b_rdata    (b_rdata),
        .bank_en    (bank_en),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .bank_rdata (bank_rdata)
    );

    function automatic logic [7:0] init_val(input logic [7:0] addr);
        case (addr)
            8'h10:   return 8'h5A;
            8'h02:   return 8'h11;
            8'h03:   return 8'h22;
            default: return addr ^ 8'hC3;
        endcase
    endfunction

    function automatic vec_t mk(input logic ar, input logic aw, input logic [7:0] aa,
                                input logic [7:0] ad, input logic br, input logic bl,
                                input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                                input logic ea, input logic eb);
        vec_t v;
        v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
        v.b_req = br; v.b_lock = bl; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
        v.exp_a_gnt = ea; v.exp_b_gnt = eb;
        return v;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port bank: write-first, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (bank_en) begin
            if (bank_we) begin
                mem[bank_addr]     <= bank_wdata;
                written[bank_addr] <= 1'b1;
                bank_rdata         <= bank_wdata;
            end else begin
                bank_rdata <= written[bank_addr] ? mem[bank_addr] : init_val(bank_addr);
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_returns();
        logic       exp_a, exp_b;
        logic [7:0] exp_d;
        rd_exp_t    e;
        exp_a = 1'b0;
        exp_b = 1'b0;
        exp_d = 8'h00;
        while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
            e = rd_q.pop_front();
            n_checks++;
            n_fail++;
            $display("[TB] FAIL stale_read: return due in cycle %0d never seen", e.due);
        end
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            e = rd_q.pop_front();
            exp_a = !e.is_b;
            exp_b = e.is_b;
            exp_d = e.data;
        end
        check_output("a_rvalid", 32'(a_rvalid), 32'(exp_a));
        check_output("b_rvalid", 32'(b_rvalid), 32'(exp_b));
        if (exp_a) check_output("a_rdata", 32'(a_rdata), 32'(exp_d));
        if (exp_b) check_output("b_rdata", 32'(b_rdata), 32'(exp_d));
    endtask

    // Read-return monitor, sampled 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #2;
            if (mon_en) check_returns();
        end
    end

    task automatic drive_idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
    endtask

    task automatic apply_stimulus(input vec_t v, input string tag);
        logic       exp_we;
        logic [7:0] exp_addr, exp_wdata;
        rd_exp_t    e;
        @(negedge clk);
        a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_req = v.b_req; b_lock = v.b_lock; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
        #1;
        check_output($sformatf("%s.a_gnt", tag), 32'(a_gnt), 32'(v.exp_a_gnt));
        check_output($sformatf("%s.b_gnt", tag), 32'(b_gnt), 32'(v.exp_b_gnt));
        check_output($sformatf("%s.a_stall", tag), 32'(a_stall), 32'(v.a_req & ~v.exp_a_gnt));
        check_output($sformatf("%s.bank_en", tag), 32'(bank_en), 32'(v.exp_a_gnt | v.exp_b_gnt));
        if (v.exp_a_gnt || v.exp_b_gnt) begin
            exp_we    = v.exp_a_gnt ? v.a_we    : v.b_we;
            exp_addr  = v.exp_a_gnt ? v.a_addr  : v.b_addr;
            exp_wdata = v.exp_a_gnt ? v.a_wdata : v.b_wdata;
            check_output($sformatf("%s.bank_we", tag), 32'(bank_we), 32'(exp_we));
            check_output($sformatf("%s.bank_addr", tag), 32'(bank_addr), 32'(exp_addr));
            if (exp_we) begin
                check_output($sformatf("%s.bank_wdata", tag), 32'(bank_wdata), 32'(exp_wdata));
                exp_mem[exp_addr] = exp_wdata;
            end else begin
                e.is_b = v.exp_b_gnt;
                e.data = exp_mem[exp_addr];
                e.due  = cyc + 1;
                rd_q.push_back(e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, vector table, lock timeout, reset mid-read.
    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; mon_en = 1'b0;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(8'(i));
        drive_idle();
        rstn = 1'b1;
        #2;
        rstn = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        #1;
        check_output("rst.a_gnt", 32'(a_gnt), 32'd0);
        check_output("rst.b_gnt", 32'(b_gnt), 32'd0);
        check_output("rst.bank_en", 32'(bank_en), 32'd0);
        check_output("rst.a_rvalid", 32'(a_rvalid), 32'd0);
        check_output("rst.b_rvalid", 32'(b_rvalid), 32'd0);
        check_output("rst.a_rdata", 32'(a_rdata), 32'd0);
        check_output("rst.b_rdata", 32'(b_rdata), 32'd0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rstn = 1'b1;
        mon_en = 1'b1;

        //            ar aw  aaddr  awd   br bl bw  baddr  bwd   eA eB
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0)); // A-only read 0x5A
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0)); // idle
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h20, 8'h77, 0, 1)); // B write
        tbl.push_back(mk(1, 0, 8'h20, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0)); // read after write
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0)); // cross-tag A 0x11
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h03, 8'h00, 0, 1)); // cross-tag B 0x22
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h03, 8'h00, 1, 0)); // tie 1 -> A
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h03, 8'h00, 0, 1)); // tie 2 -> B
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h03, 8'h00, 1, 0)); // tie 3 -> A
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h03, 8'h00, 0, 1)); // tie 4 -> B
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h3C, 0, 1));
        tbl.push_back(mk(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h21, 8'h99, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h21, 8'h00, 0, 1)); // B write then read
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h50, 8'h01, 0, 1)); // lock entry
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 1, 1, 1, 8'h51, 8'h02, 0, 1)); // locked B wins tie
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 1, 1, 1, 8'h52, 8'h03, 0, 1));
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0)); // b_req drop exits
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h50, 8'h00, 1, 0)); // prio A after exit
        tbl.push_back(mk(1, 0, 8'h02, 8'h00, 1, 0, 0, 8'h50, 8'h00, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 1, 8'h53, 8'h04, 0, 1)); // lock entry
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h54, 8'h05, 0, 1)); // b_lock=0 exits
        tbl.push_back(mk(1, 0, 8'h51, 8'h00, 1, 1, 0, 8'h52, 8'h00, 1, 0)); // unlocked tie -> A
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0));
        foreach (tbl[i]) apply_stimulus(tbl[i], $sformatf("vec%0d", i));

        // B holds the lock continuously; A joins at B's 3rd beat and must win beat 17.
        for (int k = 1; k <= 17; k++) begin
            apply_stimulus(mk(k >= 3, 0, 8'h51, 8'h00, 1, 1, 1, 8'(8'h60 + k), 8'(k),
                              k == 17, k <= 16), $sformatf("lock%0d", k));
        end
        apply_stimulus(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0), "lock_idle");
        apply_stimulus(mk(1, 0, 8'h6F, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0), "lock_rdback");
        apply_stimulus(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0), "pre_rst_idle");

        // Reset asserted while a B read is being issued.
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h03;
        #1;
        check_output("midrst.b_gnt_pre", 32'(b_gnt), 32'd1);
        #1;
        rstn = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
        #1;
        check_output("midrst.bank_en", 32'(bank_en), 32'd0);
        check_output("midrst.b_gnt", 32'(b_gnt), 32'd0);
        check_output("midrst.a_gnt", 32'(a_gnt), 32'd0);
        @(posedge clk);
        #1;
        check_output("midrst.a_rvalid", 32'(a_rvalid), 32'd0);
        check_output("midrst.b_rvalid", 32'(b_rvalid), 32'd0);
        check_output("midrst.a_rdata", 32'(a_rdata), 32'd0);
        check_output("midrst.b_rdata", 32'(b_rdata), 32'd0);
        check_output("midrst.bank_en_edge", 32'(bank_en), 32'd0);
        @(negedge clk);
        drive_idle();
        rstn = 1'b1;
        apply_stimulus(mk(1, 0, 8'h10, 8'h00, 1, 0, 0, 8'h03, 8'h00, 1, 0), "postrst_tie");
        apply_stimulus(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0), "postrst_idle");
        @(posedge clk);
        #3;
        check_output("scoreboard_empty", 32'(rd_q.size()), 32'd0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
